// File: rtl/div_pkg.sv
// Shared definitions for the ALU's multi-cycle units: FSM state encodings
// and the result constant returned on divide-by-zero.
package div_pkg;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_ITER = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;
    localparam logic [1:0] DIV_DONE = 2'd3;

    // Divide-by-zero quotient is this bit replicated across the result width.
    localparam logic DIV_ZERO_Q_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {A,Q} left, trial-subtract M,
// restore on a negative result and shift the outcome bit into Q.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {a[WIDTH-1:0], q[WIDTH-1]};
        diff    = shifted - {1'b0, m};
        if (diff[WIDTH]) begin
            a_next = shifted;
            q_next = {q[WIDTH-2:0], 1'b0};
        end else begin
            a_next = diff;
            q_next = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider, one restoring step per clock,
// with a start/done handshake and early divide-by-zero completion.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic             neg_dvd;
    logic             neg_dvs;
    logic             zero_pend;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] qreg;
    logic [WIDTH-1:0] mreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] q_nxt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a      (acc),
        .q      (qreg),
        .m      (mreg),
        .a_next (acc_nxt),
        .q_next (q_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= DIV_IDLE;
            neg_dvd     <= 1'b0;
            neg_dvs     <= 1'b0;
            zero_pend   <= 1'b0;
            acc         <= '0;
            qreg        <= '0;
            mreg        <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        neg_dvd     <= signed_op & dividend[WIDTH-1];
                        neg_dvs     <= signed_op & divisor[WIDTH-1];
                        qreg        <= (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
                        mreg        <= (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
                        acc         <= '0;
                        cnt         <= '0;
                        zero_pend   <= (divisor == '0);
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        // A zero divisor skips the iterations but still takes the
                        // FIX edge, so done follows the accept by exactly two cycles.
                        state       <= (divisor == '0) ? DIV_FIX : DIV_ITER;
                    end
                end
                DIV_ITER: begin
                    acc  <= acc_nxt;
                    qreg <= q_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    if (zero_pend) begin
                        // Undo the magnitude conversion to hand back the raw dividend.
                        quotient    <= {WIDTH{DIV_ZERO_Q_BIT}};
                        remainder   <= neg_dvd ? -qreg : qreg;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= (neg_dvd ^ neg_dvs) ? -qreg : qreg;
                        remainder   <= neg_dvd ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DIV_DONE;
                end
                DIV_DONE: begin
                    state <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=32): expected results and timing are
// queued when an operation is driven and compared when done is observed.
module tb_seq_divider;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           busy_cycles;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint la, lb, lq, lr;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.dbz = 1'b1;
            e.lat = 2;
            e.busy_cycles = 1;
        end else begin
            if (s) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
            end else begin
                la = longint'({32'd0, a});
                lb = longint'({32'd0, b});
            end
            lq = la / lb;
            lr = la % lb;
            e.q = lq[W-1:0];
            e.r = lr[W-1:0];
            e.dbz = 1'b0;
            e.lat = W + 2;
            e.busy_cycles = W + 1;
        end
        return e;
    endfunction

    // Called #1 after a rising edge with the DUT idle.
    task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit chaos);
        exp_t e;
        int   n;
        int   bc;
        sb.push_back(model(s, a, b));
        signed_op = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n  = 1;
        bc = 0;
        while (!done && n < 200) begin
            if (busy) bc++;
            if (chaos) begin
                start     = 1'($urandom);
                signed_op = 1'($urandom);
                dividend  = $urandom;
                divisor   = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        e = sb.pop_front();
        if (!done) begin
            check_val({tag, " timeout"}, 32'(done), 32'd1);
        end else begin
            check_val({tag, " quotient"}, quotient, e.q);
            check_val({tag, " remainder"}, remainder, e.r);
            check_val({tag, " dbz"}, 32'(div_by_zero), 32'(e.dbz));
            check_val({tag, " latency"}, 32'(n), 32'(e.lat));
            check_val({tag, " busy cycles"}, 32'(bc), 32'(e.busy_cycles));
            check_val({tag, " busy at done"}, 32'(busy), 32'd0);
        end
        // done must be a single pulse and results must hold afterwards.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val({tag, " done pulse"}, 32'(done), 32'd0);
        end
        check_val({tag, " held quotient"}, quotient, e.q);
    endtask

    initial begin
        int extra;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset busy", 32'(busy), 32'd0);
        check_val("reset done", 32'(done), 32'd0);
        check_val("reset dbz", 32'(div_by_zero), 32'd0);
        check_val("reset quotient", quotient, 32'd0);
        check_val("reset remainder", remainder, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("u100/7", 1'b0, 32'd100, 32'd7, 1'b0);
        run_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("u-7bits/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("u max/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0);
        run_op("u dbz", 1'b0, 32'd1234, 32'd0, 1'b0);
        run_op("s dbz", 1'b1, 32'd1234, 32'd0, 1'b0);
        run_op("s dbz neg", 1'b1, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("clear dbz", 1'b0, 32'd20, 32'd3, 1'b0);
        run_op("handshake", 1'b0, 32'd50, 32'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op("random", 1'($urandom), $urandom, $urandom_range(1, 1000), 1'b0);
        end

        // Reset midway through the iterations discards the operation.
        signed_op = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("midreset busy", 32'(busy), 32'd0);
        check_val("midreset done", 32'(done), 32'd0);
        check_val("midreset dbz", 32'(div_by_zero), 32'd0);
        check_val("midreset quotient", quotient, 32'd0);
        check_val("midreset remainder", remainder, 32'd0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        check_val("midreset idle", 32'(extra), 32'd0);
        run_op("after reset 9/4", 1'b0, 32'd9, 32'd4, 1'b0);

        check_val("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
